// File: rtl/instr_regfile_read.sv
// Front end of the single-cycle datapath: R-type field decode plus a 32 x XLEN register
// file with two asynchronous read ports and one synchronous write port.
// Optional build macro REGFILE_BYPASS_EN forwards the in-flight write onto the read ports.
module instr_regfile_read #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            reg_write,
    input  logic [XLEN-1:0] write_data,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2
);

    // Storage holds (value XOR index), so all-zero storage at power-up or after reset
    // reads back as regs[i] = i without needing an initialiser.
    logic [XLEN-1:0] r_regs [NREGS];

    logic [XLEN-1:0] w_stored1;
    logic [XLEN-1:0] w_stored2;
    logic            w_wr_en;

    function automatic logic [XLEN-1:0] idx_ext(input logic [4:0] idx);
        return {{(XLEN-5){1'b0}}, idx};
    endfunction

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign w_wr_en = reg_write && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= write_data ^ idx_ext(rd);
        end
    end

    assign w_stored1 = r_regs[rs1] ^ idx_ext(rs1);
    assign w_stored2 = r_regs[rs2] ^ idx_ext(rs2);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = w_wr_en && !reset && (rs1 == rd);
    assign w_fwd2 = w_wr_en && !reset && (rs2 == rd);

    always_comb begin
        ReadData1 = w_stored1;
        ReadData2 = w_stored2;
        if (w_fwd1) ReadData1 = write_data;
        if (w_fwd2) ReadData2 = write_data;
        // x0 is hardwired regardless of storage or forwarding
        if (rs1 == 5'd0) ReadData1 = '0;
        if (rs2 == 5'd0) ReadData2 = '0;
    end
`else
    always_comb begin
        ReadData1 = w_stored1;
        ReadData2 = w_stored2;
        if (rs1 == 5'd0) ReadData1 = '0;
        if (rs2 == 5'd0) ReadData2 = '0;
    end
`endif

endmodule

// File: tb/tb_instr_regfile_read.sv
// Directed self-checking bench for instr_regfile_read; expectations track REGFILE_BYPASS_EN.
module tb_instr_regfile_read;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        reg_write;
    logic [63:0] write_data;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks = 0;
    int errors = 0;

    instr_regfile_read #(.XLEN(64), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .reg_write(reg_write),
        .write_data(write_data), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] f_rs2, input logic [4:0] f_rs1,
                                          input logic [4:0] f_rd);
        return {7'h00, f_rs2, f_rs1, 3'h0, f_rd, 7'h33};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        instruction = 32'h00000000;
        #1;
        checks++; if (rs1 !== 5'd0) begin errors++; $display("FAIL rst_rs1 got %0d exp 0", rs1); end
        checks++; if (rs2 !== 5'd0) begin errors++; $display("FAIL rst_rs2 got %0d exp 0", rs2); end
        checks++; if (opcode !== 7'h00) begin errors++; $display("FAIL rst_opcode got %h exp 00", opcode); end
        checks++; if (ReadData1 !== 64'h0) begin errors++; $display("FAIL rst_rd1 got %h exp 0", ReadData1); end
        checks++; if (ReadData2 !== 64'h0) begin errors++; $display("FAIL rst_rd2 got %h exp 0", ReadData2); end
        instruction = 32'h01000000;
        #1;
        checks++; if (rs2 !== 5'd16) begin errors++; $display("FAIL rst16_rs2 got %0d exp 16", rs2); end
        checks++; if (rs1 !== 5'd0) begin errors++; $display("FAIL rst16_rs1 got %0d exp 0", rs1); end
        checks++; if (funct7 !== 7'h00) begin errors++; $display("FAIL rst16_f7 got %h exp 00", funct7); end
        checks++; if (ReadData1 !== 64'h0) begin errors++; $display("FAIL rst16_rd1 got %h exp 0", ReadData1); end
        checks++; if (ReadData2 !== 64'h10) begin errors++; $display("FAIL rst16_rd2 got %h exp 10", ReadData2); end
        // every register holds its own index after reset
        for (int i = 0; i < 32; i++) begin
            instruction = rtype(5'(31 - i), 5'(i), 5'd0);
            #1;
            checks++; if (ReadData1 !== 64'(i)) begin errors++; $display("FAIL rst_sweep_rd1[%0d] got %h exp %h", i, ReadData1, 64'(i)); end
            checks++; if (ReadData2 !== 64'(31 - i)) begin errors++; $display("FAIL rst_sweep_rd2[%0d] got %h exp %h", i, ReadData2, 64'(31 - i)); end
        end
    endtask

    task automatic test_decode();
        instruction = 32'h003100B3;
        #1;
        checks++; if (opcode !== 7'h33) begin errors++; $display("FAIL add_opcode got %h exp 33", opcode); end
        checks++; if (rd !== 5'd1) begin errors++; $display("FAIL add_rd got %0d exp 1", rd); end
        checks++; if (rs1 !== 5'd2) begin errors++; $display("FAIL add_rs1 got %0d exp 2", rs1); end
        checks++; if (rs2 !== 5'd3) begin errors++; $display("FAIL add_rs2 got %0d exp 3", rs2); end
        checks++; if (funct3 !== 3'd0) begin errors++; $display("FAIL add_f3 got %0d exp 0", funct3); end
        checks++; if (funct7 !== 7'h00) begin errors++; $display("FAIL add_f7 got %h exp 00", funct7); end
        checks++; if (ReadData1 !== 64'h2) begin errors++; $display("FAIL add_rd1 got %h exp 2", ReadData1); end
        checks++; if (ReadData2 !== 64'h3) begin errors++; $display("FAIL add_rd2 got %h exp 3", ReadData2); end
        instruction = 32'h407302B3;  // sub x5, x6, x7
        #1;
        checks++; if (funct7 !== 7'h20) begin errors++; $display("FAIL sub_f7 got %h exp 20", funct7); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL sub_rd got %0d exp 5", rd); end
        checks++; if (ReadData1 !== 64'h6) begin errors++; $display("FAIL sub_rd1 got %h exp 6", ReadData1); end
        checks++; if (ReadData2 !== 64'h7) begin errors++; $display("FAIL sub_rd2 got %h exp 7", ReadData2); end
        instruction = 32'hFFFFFFFF;
        #1;
        checks++; if (opcode !== 7'h7F) begin errors++; $display("FAIL ones_opcode got %h exp 7f", opcode); end
        checks++; if (funct3 !== 3'd7) begin errors++; $display("FAIL ones_f3 got %0d exp 7", funct3); end
        checks++; if (rs1 !== 5'd31) begin errors++; $display("FAIL ones_rs1 got %0d exp 31", rs1); end
        checks++; if (ReadData2 !== 64'd31) begin errors++; $display("FAIL ones_rd2 got %h exp 1f", ReadData2); end
    endtask

    task automatic test_write_read();
        logic [63:0] pre_exp;
        @(negedge clk);
        instruction = rtype(5'd0, 5'd5, 5'd5);
        reg_write   = 1'b1;
        write_data  = 64'hDEADBEEF_CAFEF00D;
`ifdef REGFILE_BYPASS_EN
        pre_exp = 64'hDEADBEEF_CAFEF00D;
`else
        pre_exp = 64'h5;
`endif
        #1;
        checks++; if (ReadData1 !== pre_exp) begin errors++; $display("FAIL wr_pre_edge got %h exp %h", ReadData1, pre_exp); end
        tick();
        reg_write = 1'b0;
        #1;
        checks++; if (ReadData1 !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL wr_post_edge got %h exp deadbeefcafef00d", ReadData1); end
        instruction = rtype(5'd5, 5'd4, 5'd0);
        #1;
        checks++; if (ReadData2 !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL wr_port2 got %h exp deadbeefcafef00d", ReadData2); end
        checks++; if (ReadData1 !== 64'h4) begin errors++; $display("FAIL wr_neighbour got %h exp 4", ReadData1); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        instruction = rtype(5'd0, 5'd0, 5'd0);
        reg_write   = 1'b1;
        write_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (ReadData1 !== 64'h0) begin errors++; $display("FAIL x0_pre_edge got %h exp 0", ReadData1); end
        tick();
        reg_write = 1'b0;
        #1;
        checks++; if (ReadData1 !== 64'h0) begin errors++; $display("FAIL x0_rd1 got %h exp 0", ReadData1); end
        checks++; if (ReadData2 !== 64'h0) begin errors++; $display("FAIL x0_rd2 got %h exp 0", ReadData2); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        reg_write   = 1'b1;
        instruction = rtype(5'd0, 5'd0, 5'd10);
        write_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        instruction = rtype(5'd0, 5'd0, 5'd11);
        write_data  = 64'h8000_0000_0000_0001;
        tick();
        reg_write   = 1'b0;
        instruction = rtype(5'd11, 5'd10, 5'd0);
        #1;
        checks++; if (ReadData1 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL b2b_x10 got %h exp 0123456789abcdef", ReadData1); end
        checks++; if (ReadData2 !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL b2b_x11 got %h exp 8000000000000001", ReadData2); end
        instruction = rtype(5'd10, 5'd10, 5'd0);
        #1;
        checks++; if (ReadData1 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL same_rd1 got %h exp 0123456789abcdef", ReadData1); end
        checks++; if (ReadData2 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL same_rd2 got %h exp 0123456789abcdef", ReadData2); end
        @(negedge clk);
        reg_write   = 1'b1;
        instruction = rtype(5'd0, 5'd0, 5'd31);
        write_data  = 64'h5555_AAAA_5555_AAAA;
        tick();
        reg_write   = 1'b0;
        instruction = rtype(5'd31, 5'd30, 5'd0);
        #1;
        checks++; if (ReadData2 !== 64'h5555_AAAA_5555_AAAA) begin errors++; $display("FAIL x31_rd2 got %h exp 5555aaaa5555aaaa", ReadData2); end
        checks++; if (ReadData1 !== 64'd30) begin errors++; $display("FAIL x30_rd1 got %h exp 1e", ReadData1); end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        instruction = rtype(5'd5, 5'd7, 5'd7);
        reg_write   = 1'b1;
        write_data  = 64'h1234;
        reset       = 1'b1;
        #1;
        checks++; if (ReadData1 !== 64'h7) begin errors++; $display("FAIL rstpri_pre_edge got %h exp 7", ReadData1); end
        tick();
        reset     = 1'b0;
        reg_write = 1'b0;
        #1;
        checks++; if (ReadData1 !== 64'h7) begin errors++; $display("FAIL rstpri_x7 got %h exp 7", ReadData1); end
        checks++; if (ReadData2 !== 64'h5) begin errors++; $display("FAIL rstpri_x5 got %h exp 5", ReadData2); end
        instruction = rtype(5'd11, 5'd10, 5'd0);
        #1;
        checks++; if (ReadData1 !== 64'd10) begin errors++; $display("FAIL rstpri_x10 got %h exp a", ReadData1); end
        checks++; if (ReadData2 !== 64'd11) begin errors++; $display("FAIL rstpri_x11 got %h exp b", ReadData2); end
    endtask

    initial begin
        reset       = 1'b1;
        reg_write   = 1'b0;
        instruction = 32'h0;
        write_data  = 64'h0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_decode();
        test_write_read();
        test_x0();
        test_back_to_back();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
